// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared ROB depth, row and completion types
package reorder_buffer_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_IW    = $clog2(ROB_DEPTH);
  localparam int PREG_W    = 6;

  typedef struct packed {
    logic              valid;
    logic              complete;
    logic [ROB_IW-1:0] rob_number;
    logic [PREG_W-1:0] preg_dst;
    logic [PREG_W-1:0] old_preg_dst;
    logic              reg_write;
    logic              mem_write;
    logic              mem_to_reg;
    logic [31:0]       data;
  } rob_row_struct;

  typedef struct packed {
    logic              valid;
    logic [ROB_IW-1:0] rob_number;
    logic [31:0]       data;
  } fu_cpl_struct;
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch/FU/retire bundle between the core and the ROB
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH   = ROB_DEPTH,
  parameter int ALLOC_W = 2,
  parameter int CPL_W   = 3,
  parameter int RET_W   = 2
);
  rob_row_struct          i_alloc             [ALLOC_W];
  logic                   o_alloc_ready;
  fu_cpl_struct           i_fu_cpl            [CPL_W];
  rob_row_struct          o_complete_rob_rows [CPL_W];
  rob_row_struct          o_retire            [RET_W];
  logic [$clog2(DEPTH):0] o_count;
  logic                   o_order_err;
  logic                   o_overflow;

  modport master (
    output i_alloc, i_fu_cpl,
    input  o_alloc_ready, o_complete_rob_rows, o_retire, o_count, o_order_err, o_overflow
  );

  modport slave (
    input  i_alloc, i_fu_cpl,
    output o_alloc_ready, o_complete_rob_rows, o_retire, o_count, o_order_err, o_overflow
  );
endinterface

// File: rtl/reorder_buffer_retire_select.sv
// rob_retire_select: contiguous retire mask from the head; a slot retires only if all older slots do
module rob_retire_select #(
  parameter int RET_W = 2
) (
  input  logic [RET_W-1:0] i_valid,
  input  logic [RET_W-1:0] i_complete,
  output logic [RET_W-1:0] o_mask
);
  logic run;

  // scan from head, stopping at the first entry that is not ready
  always_comb begin
    o_mask = '0;
    run = 1'b1;
    for (int i = 0; i < RET_W; i++) begin
      o_mask[i] = run & i_valid[i] & i_complete[i];
      run = o_mask[i];
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB, in-order alloc/retire, multi-port completion; ROB_FLUSH_EN adds i_flush
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH   = ROB_DEPTH,
  parameter int ALLOC_W = 2,
  parameter int CPL_W   = 3,
  parameter int RET_W   = 2
) (
  input logic             i_clk,
  input logic             i_rst_n,
`ifdef ROB_FLUSH_EN
  input logic             i_flush,
`endif
  reorder_buffer_if.slave rob
);
  localparam int IW = $clog2(DEPTH);
  typedef logic [IW-1:0] idx_t;

  rob_row_struct ent_q [DEPTH];
  rob_row_struct ent_d [DEPTH];
  rob_row_struct cpl_q [CPL_W];
  rob_row_struct cpl_d [CPL_W];
  rob_row_struct ret_q [RET_W];
  rob_row_struct ret_d [RET_W];
  idx_t          head_q, head_d, tail_q, tail_d, wr_idx, ci;
  logic [IW:0]   count_q, count_d, n_alloc, n_ret;
  logic          err_q, err_d, ovf_q, ovf_d, alloc_ready, alloc_any;
  logic [RET_W-1:0] head_v, head_c, ret_mask;

  // readiness comes from registered occupancy only, so retires this cycle cannot raise it
  assign alloc_ready = count_q <= (IW+1)'(DEPTH - ALLOC_W);

  assign rob.o_alloc_ready       = alloc_ready;
  assign rob.o_count             = count_q;
  assign rob.o_order_err         = err_q;
  assign rob.o_overflow          = ovf_q;
  assign rob.o_complete_rob_rows = cpl_q;
  assign rob.o_retire            = ret_q;

  // status of the oldest RET_W entries for the retire scan
  always_comb begin
    for (int i = 0; i < RET_W; i++) begin
      head_v[i] = ent_q[head_q + idx_t'(i)].valid;
      head_c[i] = ent_q[head_q + idx_t'(i)].complete;
    end
  end

  rob_retire_select #(.RET_W(RET_W)) u_retire_select (
    .i_valid   (head_v),
    .i_complete(head_c),
    .o_mask    (ret_mask)
  );

  // completion, then retire, then allocation; the three touch disjoint live entries
  always_comb begin
    ent_d = ent_q;
    err_d = err_q;
    wr_idx = tail_q;
    ci = '0;
    n_alloc = '0;
    n_ret = '0;
    alloc_any = 1'b0;
    for (int k = 0; k < CPL_W; k++) begin
      cpl_d[k] = '0;
      ci = idx_t'(rob.i_fu_cpl[k].rob_number);
      if (rob.i_fu_cpl[k].valid && ent_q[ci].valid) begin
        ent_d[ci].complete = 1'b1;
        ent_d[ci].data = rob.i_fu_cpl[k].data;
        cpl_d[k] = ent_d[ci];
      end
    end
    for (int i = 0; i < RET_W; i++) begin
      ret_d[i] = ret_mask[i] ? ent_q[head_q + idx_t'(i)] : '0;
      if (ret_mask[i]) ent_d[head_q + idx_t'(i)].valid = 1'b0;
      n_ret = n_ret + (IW+1)'(ret_mask[i]);
    end
    for (int j = 0; j < ALLOC_W; j++) begin
      alloc_any = alloc_any | rob.i_alloc[j].valid;
      if (alloc_ready && rob.i_alloc[j].valid) begin
        ent_d[wr_idx] = rob.i_alloc[j];
        ent_d[wr_idx].complete = 1'b0;
        ent_d[wr_idx].data = '0;
        err_d = err_d | (idx_t'(rob.i_alloc[j].rob_number) != wr_idx);
        wr_idx = wr_idx + idx_t'(1);
        n_alloc = n_alloc + (IW+1)'(1);
      end
    end
    ovf_d = ovf_q | (alloc_any & ~alloc_ready);
    head_d = head_q + idx_t'(n_ret);
    tail_d = wr_idx;
    count_d = count_q + n_alloc - n_ret;
`ifdef ROB_FLUSH_EN
    if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      for (int k = 0; k < CPL_W; k++) cpl_d[k] = '0;
      for (int i = 0; i < RET_W; i++) ret_d[i] = '0;
      err_d = err_q;
      ovf_d = ovf_q;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end
`endif
  end

  // state and registered broadcast/retire outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ent_q <= '{default: '0};
      cpl_q <= '{default: '0};
      ret_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      cpl_q <= cpl_d;
      ret_q <= ret_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
